// File: rtl/ad7886_rx.sv
// AD7886 serial capture: one chip-select / SCLK frame per divided sample clock edge.
// Optional TWOS_COMP_EN: invert result MSB at capture (offset-binary -> two's complement).
module ad7886_rx #(
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic              adc_sdata,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              overrun
);

  localparam int HC_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        sync_reg;
  logic              start;
  logic [HC_W-1:0]   hc_reg, hc_next;
  logic [BC_W-1:0]   bc_reg, bc_next;
  // Only the trailing DATA_W bits of a frame form the result; the leading
  // frame bits are shifted out of the top and never needed.
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              cs_n_reg, cs_n_next;
  logic              sclk_reg, sclk_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              overrun_reg, overrun_next;
  logic [DATA_W-1:0] capture;

  // Two synchroniser flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], sample_clk};
    end
  end

  assign start = sync_reg[1] & ~sync_reg[2];

`ifdef TWOS_COMP_EN
  assign capture = {~shift_reg[DATA_W-1], shift_reg[DATA_W-2:0]};
`else
  assign capture = shift_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      hc_reg      <= '0;
      bc_reg      <= '0;
      shift_reg   <= '0;
      cs_n_reg    <= 1'b1;
      sclk_reg    <= 1'b1;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hc_reg      <= hc_next;
      bc_reg      <= bc_next;
      shift_reg   <= shift_next;
      cs_n_reg    <= cs_n_next;
      sclk_reg    <= sclk_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hc_next      = hc_reg;
    bc_next      = bc_reg;
    shift_next   = shift_reg;
    cs_n_next    = cs_n_reg;
    sclk_next    = sclk_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    overrun_next = start && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        cs_n_next = 1'b1;
        sclk_next = 1'b1;
        if (start) begin
          state_next = SETUP;
          cs_n_next  = 1'b0;
          hc_next    = '0;
          bc_next    = '0;
          shift_next = '0;
        end
      end

      SETUP: begin
        if (hc_reg == HC_LAST) begin
          hc_next    = '0;
          sclk_next  = 1'b0;
          state_next = SHIFT;
        end else begin
          hc_next = hc_reg + 1'b1;
        end
      end

      SHIFT: begin
        // sclk_reg doubles as the half-period phase: low phase ends with a
        // rising edge and a data capture, high phase ends the bit.
        if (hc_reg != HC_LAST) begin
          hc_next = hc_reg + 1'b1;
        end else begin
          hc_next = '0;
          if (!sclk_reg) begin
            sclk_next  = 1'b1;
            shift_next = {shift_reg[DATA_W-2:0], adc_sdata};
            bc_next    = bc_reg + 1'b1;
          end else if (bc_reg == BC_LAST) begin
            state_next = DONE;
            cs_n_next  = 1'b1;
            data_next  = capture;
            valid_next = 1'b1;
          end else begin
            sclk_next = 1'b0;
          end
        end
      end

      DONE: begin
        cs_n_next  = 1'b1;
        sclk_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b1;
      end
    endcase
  end

  assign adc_cs_n   = cs_n_reg;
  assign adc_sclk   = sclk_reg;
  assign data       = data_reg;
  assign data_valid = valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_ad7886_rx.sv
// Directed bench for ad7886_rx with a behavioural AD7886 serial-output model.
module tb_ad7886_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_clk = 1'b0;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] data;
  logic        data_valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic [15:0] adc_word = 16'h0000;
  int bit_idx = 0;
  int rise_cnt = 0;
  int dv_cnt = 0;
  int ov_cnt = 0;

  ad7886_rx #(.SCLK_DIV(4), .FRAME_BITS(16), .DATA_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .adc_sdata  (adc_sdata),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .data       (data),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  // ADC model: next bit MSB-first on each SCLK falling edge while selected.
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n === 1'b1) begin
      bit_idx = 0;
    end else if (bit_idx < 16) begin
      adc_sdata = adc_word[15 - bit_idx];
      bit_idx++;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) rise_cnt++;
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  function automatic logic [11:0] exp_code(input logic [11:0] raw);
`ifdef TWOS_COMP_EN
    return raw ^ 12'h800;
`else
    return raw;
`endif
  endfunction

  // Raise sample_clk just after a falling clk edge, run 400 cycles, report latency
  // from the internal start pulse (visible two cycles after the raise) to data_valid.
  task automatic run_frame(input logic [15:0] word, output int lat);
    adc_word   = word;
    sample_clk = 1'b1;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (k == 200) sample_clk = 1'b0;
      @(negedge clk);
      if (data_valid === 1'b1 && lat < 0) lat = k - 2;
    end
    $display("frame word=%04h data=%03h latency=%0d sclk_rises=%0d", word, data, lat, rise_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_clk = ~sample_clk;
      repeat (10) @(negedge clk);
    end
    sample_clk = 1'b0;
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b want=1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b want=1", adc_sclk); end
    checks++; if (data !== 12'h000) begin failures++; $display("FAIL reset_data got=%03h want=000", data); end
    checks++; if (dv_cnt !== 0) begin failures++; $display("FAIL reset_valid got=%0d want=0", dv_cnt); end
    checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL reset_overrun got=%0d want=0", ov_cnt); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (adc_cs_n !== 1'b1 || rise_cnt !== 0) begin
      failures++; $display("FAIL post_reset_idle cs_n=%b rises=%0d want cs_n=1 rises=0", adc_cs_n, rise_cnt);
    end
    $display("reset cs_n=%b sclk=%b data=%03h", adc_cs_n, adc_sclk, data);
  endtask

  task automatic test_single_frame();
    int lat;
    rise_cnt = 0; dv_cnt = 0; ov_cnt = 0;
    run_frame(16'h0ABC, lat);
    checks++; if (lat !== 133) begin failures++; $display("FAIL single_latency got=%0d want=133", lat); end
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL single_sclk_rises got=%0d want=16", rise_cnt); end
    checks++; if (dv_cnt !== 1) begin failures++; $display("FAIL single_valid_pulses got=%0d want=1", dv_cnt); end
    checks++; if (data !== exp_code(12'hABC)) begin failures++; $display("FAIL single_data got=%03h want=%03h", data, exp_code(12'hABC)); end
    checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
      failures++; $display("FAIL single_idle cs_n=%b sclk=%b want 1 1", adc_cs_n, adc_sclk);
    end
    checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL single_overrun got=%0d want=0", ov_cnt); end
  endtask

  task automatic test_continuous();
    int tcyc = 0;
    int prev = -1;
    int seen;
    dv_cnt = 0; ov_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      adc_word   = 16'(f);
      sample_clk = 1'b1;
      seen = 0;
      for (int k = 0; k < 1564; k++) begin
        if (k == 782) sample_clk = 1'b0;
        @(negedge clk);
        tcyc++;
        if (data_valid === 1'b1) begin
          seen++;
          $display("cont frame=%0d data=%03h cycle=%0d", f, data, tcyc);
          checks++; if (data !== exp_code(12'(f))) begin
            failures++; $display("FAIL cont_data frame=%0d got=%03h want=%03h", f, data, exp_code(12'(f)));
          end
          if (prev >= 0) begin
            checks++; if (tcyc - prev !== 1564) begin
              failures++; $display("FAIL cont_spacing frame=%0d got=%0d want=1564", f, tcyc - prev);
            end
          end
          prev = tcyc;
        end
      end
      checks++; if (seen !== 1) begin failures++; $display("FAIL cont_valid_count frame=%0d got=%0d want=1", f, seen); end
    end
    checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL cont_overrun got=%0d want=0", ov_cnt); end
    checks++; if (dv_cnt !== 8) begin failures++; $display("FAIL cont_total_valid got=%0d want=8", dv_cnt); end
  endtask

  task automatic test_overrun();
    rise_cnt = 0; dv_cnt = 0; ov_cnt = 0;
    adc_word   = 16'h0555;
    sample_clk = 1'b1;
    repeat (25) @(negedge clk);
    sample_clk = 1'b0;
    repeat (25) @(negedge clk);
    sample_clk = 1'b1;
    repeat (300) @(negedge clk);
    sample_clk = 1'b0;
    repeat (20) @(negedge clk);
    $display("overrun pulses=%0d valid=%0d rises=%0d data=%03h", ov_cnt, dv_cnt, rise_cnt, data);
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL overrun_pulse_cycles got=%0d want=1", ov_cnt); end
    checks++; if (dv_cnt !== 1) begin failures++; $display("FAIL overrun_valid got=%0d want=1", dv_cnt); end
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL overrun_sclk_rises got=%0d want=16", rise_cnt); end
    checks++; if (data !== exp_code(12'h555)) begin failures++; $display("FAIL overrun_data got=%03h want=%03h", data, exp_code(12'h555)); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit reached = 0;
    rise_cnt = 0; dv_cnt = 0;
    adc_word   = 16'h0FFF;
    sample_clk = 1'b1;
    for (int k = 0; k < 300 && !reached; k++) begin
      @(negedge clk);
      if (rise_cnt >= 7) reached = 1;
    end
    checks++; if (!reached) begin failures++; $display("FAIL midreset_reach_bit7 rises=%0d want>=7", rise_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
      failures++; $display("FAIL midreset_async cs_n=%b sclk=%b want 1 1", adc_cs_n, adc_sclk);
    end
    checks++; if (data !== 12'h000) begin failures++; $display("FAIL midreset_data got=%03h want=000", data); end
    sample_clk = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (dv_cnt !== 0) begin failures++; $display("FAIL midreset_no_valid got=%0d want=0", dv_cnt); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rise_cnt = 0;
    run_frame(16'h0123, lat);
    checks++; if (lat !== 133) begin failures++; $display("FAIL midreset_latency got=%0d want=133", lat); end
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL midreset_sclk_rises got=%0d want=16", rise_cnt); end
    checks++; if (data !== exp_code(12'h123)) begin failures++; $display("FAIL midreset_data_after got=%03h want=%03h", data, exp_code(12'h123)); end
    checks++; if (dv_cnt !== 1) begin failures++; $display("FAIL midreset_valid_after got=%0d want=1", dv_cnt); end
  endtask

  task automatic test_twos_comp();
    logic [11:0] raw [3];
    logic [11:0] want [3];
    int lat;
    raw[0] = 12'h800; raw[1] = 12'hFFF; raw[2] = 12'h000;
`ifdef TWOS_COMP_EN
    want[0] = 12'h000; want[1] = 12'h7FF; want[2] = 12'h800;
`else
    want[0] = 12'h800; want[1] = 12'hFFF; want[2] = 12'h000;
`endif
    for (int i = 0; i < 3; i++) begin
      run_frame({4'h0, raw[i]}, lat);
      checks++; if (data !== want[i]) begin
        failures++; $display("FAIL code_map raw=%03h got=%03h want=%03h", raw[i], data, want[i]);
      end
    end
  endtask

  task automatic test_static();
    rise_cnt = 0; dv_cnt = 0; ov_cnt = 0;
    sample_clk = 1'b0;
    repeat (300) @(negedge clk);
    $display("static rises=%0d valid=%0d overrun=%0d", rise_cnt, dv_cnt, ov_cnt);
    checks++; if (rise_cnt !== 0 || dv_cnt !== 0 || ov_cnt !== 0) begin
      failures++; $display("FAIL static_activity rises=%0d valid=%0d overrun=%0d want 0 0 0", rise_cnt, dv_cnt, ov_cnt);
    end
    checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
      failures++; $display("FAIL static_idle cs_n=%b sclk=%b want 1 1", adc_cs_n, adc_sclk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_continuous();
    test_overrun();
    test_reset_mid();
    test_twos_comp();
    test_static();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad7886_rx.md
Name: ad7886_rx

Overview:
- Serial capture stage directly downstream of the sample-rate divider: consumes the ~32 kHz divided sample clock and runs one AD7886 conversion/read frame per sample.
- Generates chip-select and serial clock, shifts in a 16-bit frame, presents 12-bit parallel data with a one-cycle valid strobe to the modulator/transmit datapath.
- Runs entirely in the clk domain; sample clock is treated as asynchronous and synchronised internally.

Parameters:
- SCLK_DIV, 4, clk cycles per SCLK half-period (>=2); SCLK = clk/(2*SCLK_DIV)
- FRAME_BITS, 16, SCLK rising edges per frame
- DATA_W, 12, result width; data = last DATA_W bits of frame, MSB first

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-low reset
- sample_clk  in  1  divided sample clock from divider; rising edge starts a frame
- adc_sdata  in  1  ADC serial data out
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock, idles high
- data  out  DATA_W  last captured sample
- data_valid  out  1  one-clk pulse when data updates
- overrun  out  1  one-clk pulse when a sample edge arrives mid-frame

Behaviour:
- Reset (rst low, async): adc_cs_n=1, adc_sclk=1, data=0, data_valid=0, overrun=0, state=IDLE, all counters/shift reg=0, synchroniser flops=0.
- sample_clk passes a 2-flop synchroniser; a third flop gives edge detect; start = sync&~prev (one clk pulse).
- States:
  - IDLE: cs_n=1, sclk=1. On start -> SETUP, cs_n driven 0 next cycle.
  - SETUP: cs_n=0, sclk=1 for SCLK_DIV cycles -> SHIFT.
  - SHIFT: per bit, sclk=0 for SCLK_DIV cycles then 1 for SCLK_DIV cycles. On the clk edge where sclk goes 0->1, adc_sdata is shifted into LSB of the FRAME_BITS shift reg and bit counter increments. After the FRAME_BITS-th high phase completes -> DONE.
  - DONE (1 cycle): cs_n=1, sclk=1, data<=shift[DATA_W-1:0], data_valid=1 -> IDLE.
- Latency: data_valid asserts exactly SCLK_DIV + 2*FRAME_BITS*SCLK_DIV + 1 clk cycles after the start pulse (default 133 cycles = 2.66 us at 50 MHz; well inside the 31.25 us sample period).
- Counters: half-period counter ceil(log2(SCLK_DIV)) bits, wraps 0..SCLK_DIV-1; bit counter 5 bits, counts 0..FRAME_BITS.
- Start while state != IDLE (including DONE): frame not restarted, edge dropped, overrun pulses one cycle; current frame completes normally.
- Start in same cycle state returns to IDLE (after DONE): accepted as a new frame.
- data holds its value between frames; only changes with data_valid.
- Reset mid-frame: immediate return to reset values; cs_n rises asynchronously; partial frame discarded, no data_valid.
- sample_clk held static: no activity, outputs stay at idle values.

Optional Feature:
- Macro TWOS_COMP_EN.
- Defined: data MSB inverted at capture (offset-binary -> two's complement for bipolar input); 0x800 raw -> 0x000, 0xFFF -> 0x7FF, 0x000 -> 0x800.
- Not defined: data = raw straight-binary ADC code. Timing identical in both builds.

Test Plan:
- Reset: hold rst=0 with sample_clk toggling -> cs_n=1, sclk=1, data=0x000, no data_valid/overrun.
- Single frame: ADC model drives frame 0x0ABC on SCLK falling edges, one sample_clk rising edge -> exactly 16 SCLK rising edges while cs_n low, data=0xABC, data_valid single pulse 133 clks after start.
- Continuous 32 kHz (divider half-period 782 clks): 8 frames of incrementing codes 0x000..0x007 -> 8 valid pulses spaced 1564 clks, data matches each code, overrun never asserts.
- Overrun: second sample_clk edge 50 clks after first -> overrun one-cycle pulse, only one frame (16 SCLKs), one data_valid.
- Reset mid-frame: assert rst at bit 7 -> cs_n=1 immediately, no data_valid; next edge after release produces a clean full frame.
- TWOS_COMP_EN build: codes 0x800, 0xFFF, 0x000 -> data 0x000, 0x7FF, 0x800; without macro -> 0x800, 0xFFF, 0x000.
